// File: rtl/slice_cfg_loader.sv
// slice_cfg_loader: checks a sync byte and an XOR checksum on a byte stream, and shifts
// the LUT INIT and FF_USED bits LSB-first into the slice configuration chain.
module slice_cfg_loader #(
    parameter int         N_SLICES  = 16,
    parameter int         K         = 3,
    parameter int         CLK_DIV   = 2,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] IN_DATA,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic       CFG_CLK,
    output logic       CFG_DATA,
    output logic       CFG_LATCH,
    output logic       USER_EN,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);
    localparam int TOTAL_BITS = N_SLICES * (2**K + 1);
    localparam int N_BYTES    = (TOTAL_BITS + 7) / 8;
    localparam int CW         = $clog2(TOTAL_BITS + 1);
    localparam int BW         = $clog2(N_BYTES + 1);
    localparam int PW         = $clog2(2 * CLK_DIV);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_SHIFT, S_CHECK, S_LATCH, S_DONE, S_ERR} state_t;
    state_t state, state_nx;

    logic [7:0]    byte_buf, sh, chk;
    logic          buf_full, act;
    logic [2:0]    sh_left;
    logic [BW-1:0] taken;
    logic [CW-1:0] bit_cnt;
    logic [PW-1:0] ph;
    logic          xfer, bit_end, last_bit, restart;

    assign IN_READY  = state == S_SYNC || state == S_CHECK ||
                       (state == S_SHIFT && !buf_full && taken < BW'(N_BYTES));
    assign xfer      = IN_VALID && IN_READY;
    assign bit_end   = act && ph == PW'(2 * CLK_DIV - 1);
    assign last_bit  = bit_end && bit_cnt == CW'(TOTAL_BITS - 1);
    assign restart   = START && (state inside {S_IDLE, S_DONE, S_ERR});
    assign BUSY      = state inside {S_SYNC, S_SHIFT, S_CHECK, S_LATCH};
    assign CFG_LATCH = state == S_LATCH;
    assign DONE      = state == S_DONE;
    assign USER_EN   = state == S_DONE;
    assign ERR       = state == S_ERR;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (restart) state_nx = S_SYNC;
        else case (state)
            S_SYNC:  if (xfer && IN_DATA == SYNC_BYTE) state_nx = S_SHIFT;
            S_SHIFT: if (last_bit) state_nx = S_CHECK;
            S_CHECK: if (xfer) state_nx = (IN_DATA == chk) ? S_LATCH : S_ERR;
            S_LATCH: state_nx = S_DONE;
            default: ;
        endcase
    end

    // byte_buf is a one-byte prefetch so the next byte arrives while sh is still clocking out
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            byte_buf <= '0;
            sh       <= '0;
            chk      <= '0;
            buf_full <= 1'b0;
            act      <= 1'b0;
            sh_left  <= '0;
            taken    <= '0;
            bit_cnt  <= '0;
            ph       <= '0;
            CFG_CLK  <= 1'b0;
            CFG_DATA <= 1'b0;
        end else if (restart) begin
            chk      <= '0;
            buf_full <= 1'b0;
            act      <= 1'b0;
            sh_left  <= '0;
            taken    <= '0;
            bit_cnt  <= '0;
            ph       <= '0;
            CFG_CLK  <= 1'b0;
            CFG_DATA <= 1'b0;
        end else if (state == S_SHIFT) begin
            if (xfer) begin
                byte_buf <= IN_DATA;
                buf_full <= 1'b1;
                taken    <= taken + BW'(1);
                chk      <= chk ^ IN_DATA;
            end
            if (last_bit) begin
                act      <= 1'b0;
                CFG_CLK  <= 1'b0;
                buf_full <= 1'b0;
                bit_cnt  <= bit_cnt + CW'(1);
            end else if (!act || bit_end) begin
                if (bit_end) bit_cnt <= bit_cnt + CW'(1);
                CFG_CLK <= 1'b0;
                ph      <= '0;
                if (sh_left != 3'd0) begin
                    CFG_DATA <= sh[0];
                    sh       <= sh >> 1;
                    sh_left  <= sh_left - 3'd1;
                    act      <= 1'b1;
                end else if (buf_full) begin
                    CFG_DATA <= byte_buf[0];
                    sh       <= byte_buf >> 1;
                    sh_left  <= 3'd7;
                    buf_full <= 1'b0;
                    act      <= 1'b1;
                end else begin
                    act <= 1'b0;
                end
            end else begin
                ph      <= ph + PW'(1);
                CFG_CLK <= ph >= PW'(CLK_DIV - 1);
            end
        end
    end
endmodule

// File: tb/tb_slice_cfg_loader.sv
// tb_slice_cfg_loader: randomized and directed loads checked against a bit-queue model of
// the configuration stream plus per-cycle CFG_CLK/CFG_DATA timing rules.
module tb_slice_cfg_loader;
    localparam int         NS   = 2;
    localparam int         KK   = 3;
    localparam int         CD   = 2;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TB   = NS * (2**KK + 1);
    localparam int         NB   = (TB + 7) / 8;

    logic CLK = 1'b0, RST = 1'b1, START = 1'b0, IN_VALID = 1'b0;
    logic [7:0] IN_DATA = 8'h00;
    logic IN_READY, CFG_CLK, CFG_DATA, CFG_LATCH, USER_EN, BUSY, DONE, ERR;

    slice_cfg_loader #(.N_SLICES(NS), .K(KK), .CLK_DIV(CD), .SYNC_BYTE(SYNC)) dut (
        .CLK(CLK), .RST(RST), .START(START), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .CFG_CLK(CFG_CLK), .CFG_DATA(CFG_DATA), .CFG_LATCH(CFG_LATCH),
        .USER_EN(USER_EN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0, failures = 0;
    int cyc = 0, edges = 0, latch_cnt = 0;
    int stable_n = 0, hi_n = 0, lo_n = 0;
    int rise_cyc[$];
    logic exp_q[$];
    logic exp_good = 1'b0;
    logic [TB-1:0] obs;
    logic prev_clk = 1'b0, prev_data = 1'b0, prev_latch = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Per-cycle compare against the model queue and the bit-period timing rules
    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            prev_clk = 1'b0; prev_data = 1'b0; prev_latch = 1'b0;
            stable_n = 0; hi_n = 0; lo_n = 0;
        end else begin
            check("user_en_vs_done", USER_EN, DONE);
            check("done_err_exclusive", DONE & ERR, 0);
            if (prev_latch) check("done_after_latch", {DONE, USER_EN}, 2'b11);
            if (CFG_LATCH) begin
                check("latch_allowed", exp_good && exp_q.size() == 0, 1);
                latch_cnt++;
            end
            stable_n = (CFG_DATA != prev_data) ? 1 : stable_n + 1;
            if (CFG_CLK) check("data_hold_high", CFG_DATA, prev_data);
            if (CFG_CLK && !prev_clk) begin
                check("low_phase_len", lo_n >= CD, 1);
                check("data_setup", stable_n > CD, 1);
                check("clk_rise_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("bit_value", CFG_DATA, exp_q.pop_front());
                if (edges < TB) obs[edges] = CFG_DATA;
                edges++;
                rise_cyc.push_back(cyc);
            end
            if (!CFG_CLK && prev_clk) check("high_phase_len", hi_n, CD);
            hi_n = CFG_CLK ? hi_n + 1 : 0;
            lo_n = CFG_CLK ? 0 : lo_n + 1;
            prev_clk = CFG_CLK; prev_data = CFG_DATA; prev_latch = CFG_LATCH;
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        IN_DATA = b;
        IN_VALID = 1'b1;
        while (!IN_READY && n < 500) begin @(negedge CLK); n++; end
        if (!IN_READY) begin
            check("send_ready_timeout", IN_READY, 1);
            IN_VALID = 1'b0;
        end else begin
            @(posedge CLK);
            @(negedge CLK);
            IN_VALID = 1'b0;
        end
    endtask

    task automatic arm(input logic [8*NB-1:0] p, input logic [7:0] cb);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < NB; i++) x ^= p[8*i +: 8];
        exp_q.delete();
        for (int i = 0; i < TB; i++) exp_q.push_back(p[i]);
        exp_good = (cb == x);
        edges = 0; latch_cnt = 0; obs = '0;
        rise_cyc.delete();
    endtask

    task automatic do_start();
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1;
        check("start_busy", BUSY, 1);
        check("start_user_en", USER_EN, 0);
        check("start_done_err", {DONE, ERR}, 0);
        check("start_ready", IN_READY, 1);
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic run_load(input logic [8*NB-1:0] p, input logic [7:0] cb, input int n_garb,
                            input int gap_after, input int gap_len, input bit rnd_start);
        logic [7:0] b;
        int n = 0;
        arm(p, cb);
        do_start();
        for (int g = 0; g < n_garb; g++) begin
            b = (g == 0) ? 8'h00 : (g == 1) ? 8'hFF : 8'($urandom_range(0, 255));
            if (b == SYNC) b = 8'h3C;
            send(b);
        end
        if (n_garb > 0) check("hunt_no_clk", edges, 0);
        send(SYNC);
        for (int i = 0; i < NB; i++) begin
            START = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
            send(p[8*i +: 8]);
            if (i == gap_after) repeat (gap_len) @(negedge CLK);
        end
        START = 1'b0;
        send(cb);
        while (!(DONE || ERR) && n < 100) begin @(negedge CLK); n++; end
        check("load_end_reached", DONE || ERR, 1);
        check("edge_count", edges, TB);
        check("bits_left", exp_q.size(), 0);
        check("latch_count", latch_cnt, {31'd0, exp_good});
        check("final_done", DONE, exp_good);
        check("final_err", ERR, !exp_good);
        check("final_user_en", USER_EN, exp_good);
        check("final_busy_ready", {BUSY, IN_READY}, 0);
    endtask

    task automatic check_spacing();
        for (int i = 1; i < rise_cyc.size(); i++)
            check("clk_spacing", rise_cyc[i] - rise_cyc[i-1], 2 * CD);
    endtask

    localparam logic [8*NB-1:0] NOM = 24'h02C35A;

    initial begin
        logic [8*NB-1:0] p;
        logic [7:0] x, cb;
        repeat (3) @(negedge CLK);
        check("reset_outputs", {IN_READY, CFG_CLK, CFG_DATA, CFG_LATCH, USER_EN, BUSY, DONE, ERR}, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("idle_not_busy", {BUSY, IN_READY}, 0);

        run_load(NOM, 8'h9B, 0, -1, 0, 0);
        check("nominal_bits", obs, 18'h2C35A);
        check("nominal_done", DONE, 1);
        check_spacing();

        run_load(NOM, 8'h00, 0, -1, 0, 0);
        check("badchk_err", ERR, 1);
        check("badchk_bits", obs, 18'h2C35A);

        run_load(NOM, 8'h9B, 2, -1, 0, 0);
        check("hunt_bits", obs, 18'h2C35A);
        check_spacing();

        run_load(NOM, 8'h9B, 0, 0, 10, 0);
        check("gap10_bits", obs, 18'h2C35A);
        run_load(NOM, 8'h9B, 0, 0, 40, 0);
        check("gap40_bits", obs, 18'h2C35A);

        run_load(NOM, 8'h9B, 0, -1, 0, 0);
        arm(NOM, 8'h9B);
        do_start();
        send(SYNC); send(8'h5A); send(8'hC3);
        begin
            int n = 0;
            while (edges < 7 && n < 300) begin @(negedge CLK); n++; end
        end
        check("reached_edge7", edges, 7);
        check("pre_reset_busy", BUSY, 1);
        #2 RST = 1'b1;
        #1 check("async_reset_outputs",
                 {IN_READY, CFG_CLK, CFG_DATA, CFG_LATCH, USER_EN, BUSY, DONE, ERR}, 0);
        @(negedge CLK);
        RST = 1'b0;
        run_load(NOM, 8'h9B, 0, -1, 0, 0);
        check("post_reset_bits", obs, 18'h2C35A);
        check_spacing();

        for (int r = 0; r < 10; r++) begin
            p = 24'($urandom());
            x = p[7:0] ^ p[15:8] ^ p[23:16];
            cb = ($urandom_range(0, 2) == 0) ? x ^ 8'($urandom_range(1, 255)) : x;
            run_load(p, cb, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 40), 1);
            check("rand_bits", obs, p[TB-1:0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
